// File: rtl/inst_fetch_ctrl.sv
// Instruction-fetch sequencer: owns the PC, drives instruction-memory address,
// and loads the IF/ID register with stall, redirect and zero-word halt handling.
module inst_fetch_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'd0,
  parameter bit          ZERO_HALT = 1'b1
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        START,
  input  logic        STALL,
  input  logic        REDIRECT,
  input  logic [31:0] REDIRECT_PC,
  output logic [31:0] MEM_ADDRESS,
  input  logic [31:0] MEM_INSTRUCTION,
  output logic [31:0] IFID_INSTR,
  output logic [31:0] IFID_PC,
  output logic        IFID_VALID,
  output logic        HALTED,
  output logic [31:0] FETCH_COUNT
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc          <= RESET_PC;
      state       <= IDLE;
      IFID_INSTR  <= '0;
      IFID_PC     <= '0;
      IFID_VALID  <= 1'b0;
      FETCH_COUNT <= '0;
    end else begin
      case (state)
        IDLE: begin
          IFID_VALID <= 1'b0;
          if (REDIRECT) pc <= REDIRECT_PC;
          else if (START) state <= FETCH;
        end
        FETCH: begin
          // Redirect outranks stall; stall outranks halt detection.
          if (REDIRECT) begin
            pc         <= REDIRECT_PC;
            IFID_VALID <= 1'b0;
          end else if (STALL) begin
            pc <= pc;
          end else if (ZERO_HALT && (MEM_INSTRUCTION == '0)) begin
            state      <= HALT;
            IFID_VALID <= 1'b0;
          end else begin
            IFID_INSTR  <= MEM_INSTRUCTION;
            IFID_PC     <= pc;
            IFID_VALID  <= 1'b1;
            pc          <= pc + 32'd1;
            FETCH_COUNT <= FETCH_COUNT + 32'd1;
          end
        end
        HALT: begin
          IFID_VALID <= 1'b0;
          if (REDIRECT) begin
            pc    <= REDIRECT_PC;
            state <= FETCH;
          end
        end
        default: begin
          state      <= IDLE;
          IFID_VALID <= 1'b0;
        end
      endcase
    end
  end

  assign MEM_ADDRESS = pc;
  assign HALTED      = (state == HALT);

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: default build plus a wrap-around build
// with zero-word halting disabled.
module tb_inst_fetch_ctrl;

  logic        clk;
  int          total;
  int          bad;

  logic        rst0, start0, stall0, redir0;
  logic [31:0] rpc0, addr0, instr0, ifid_instr0, ifid_pc0, count0;
  logic        valid0, halted0;

  logic        rst1, start1;
  logic [31:0] addr1, instr1, ifid_instr1, ifid_pc1, count1;
  logic        valid1, halted1;

  // Program 0..16 nonzero, everything else reads as the zero word.
  assign instr0 = (addr0 < 32'd17) ? (32'h1000_0000 | addr0) : 32'h0;
  // Nonzero everywhere except address 0.
  assign instr1 = (addr1 == 32'd0) ? 32'h0 : (32'hB000_0000 ^ addr1);

  inst_fetch_ctrl dut0 (
    .CLK(clk), .RST(rst0), .START(start0), .STALL(stall0),
    .REDIRECT(redir0), .REDIRECT_PC(rpc0),
    .MEM_ADDRESS(addr0), .MEM_INSTRUCTION(instr0),
    .IFID_INSTR(ifid_instr0), .IFID_PC(ifid_pc0), .IFID_VALID(valid0),
    .HALTED(halted0), .FETCH_COUNT(count0)
  );

  inst_fetch_ctrl #(.RESET_PC(32'hFFFF_FFFE), .ZERO_HALT(1'b0)) dut1 (
    .CLK(clk), .RST(rst1), .START(start1), .STALL(1'b0),
    .REDIRECT(1'b0), .REDIRECT_PC(32'h0),
    .MEM_ADDRESS(addr1), .MEM_INSTRUCTION(instr1),
    .IFID_INSTR(ifid_instr1), .IFID_PC(ifid_pc1), .IFID_VALID(valid1),
    .HALTED(halted1), .FETCH_COUNT(count1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  initial begin
    total = 0; bad = 0;
    rst0 = 1'b1; start0 = 1'b0; stall0 = 1'b0; redir0 = 1'b0; rpc0 = '0;
    rst1 = 1'b1; start1 = 1'b0;
    step();
    chk("rst_addr", addr0, 32'd0);
    chk("rst_valid", {31'b0, valid0}, 32'd0);
    chk("rst_count", count0, 32'd0);
    chk("rst_halted", {31'b0, halted0}, 32'd0);
    chk("rst_ifid_pc", ifid_pc0, 32'd0);
    chk("rst_ifid_instr", ifid_instr0, 32'd0);

    // START edge: enter FETCH, nothing delivered yet.
    rst0 = 1'b0; start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk("start_addr", addr0, 32'd0);
    chk("start_valid", {31'b0, valid0}, 32'd0);

    for (int i = 0; i < 17; i++) begin
      step();
      chk("run_pc", ifid_pc0, i);
      chk("run_valid", {31'b0, valid0}, 32'd1);
      chk("run_instr", ifid_instr0, 32'h1000_0000 | i);
      chk("run_count", count0, i + 1);
      if (i == 4) begin
        stall0 = 1'b1;
        for (int s = 0; s < 3; s++) begin
          step();
          chk("stall_pc", ifid_pc0, 32'd4);
          chk("stall_addr", addr0, 32'd5);
          chk("stall_count", count0, 32'd5);
        end
        stall0 = 1'b0;
      end
    end

    step();
    chk("halt_valid", {31'b0, valid0}, 32'd0);
    chk("halt_halted", {31'b0, halted0}, 32'd1);
    chk("halt_addr", addr0, 32'd17);
    chk("halt_count", count0, 32'd17);

    start0 = 1'b1; stall0 = 1'b1;
    step();
    start0 = 1'b0; stall0 = 1'b0;
    chk("halt_start_halted", {31'b0, halted0}, 32'd1);
    chk("halt_start_addr", addr0, 32'd17);
    chk("halt_start_count", count0, 32'd17);

    redir0 = 1'b1; rpc0 = 32'd2;
    step();
    redir0 = 1'b0;
    chk("halt_redir_halted", {31'b0, halted0}, 32'd0);
    chk("halt_redir_addr", addr0, 32'd2);
    chk("halt_redir_valid", {31'b0, valid0}, 32'd0);
    step();
    chk("after_halt_pc", ifid_pc0, 32'd2);
    chk("after_halt_valid", {31'b0, valid0}, 32'd1);
    chk("after_halt_count", count0, 32'd18);
    chk("after_halt_addr", addr0, 32'd3);

    // Redirect beats a simultaneous stall.
    redir0 = 1'b1; rpc0 = 32'd9; stall0 = 1'b1;
    step();
    redir0 = 1'b0; stall0 = 1'b0;
    chk("redir_addr", addr0, 32'd9);
    chk("redir_valid", {31'b0, valid0}, 32'd0);
    chk("redir_count", count0, 32'd18);
    step();
    chk("redir_tgt_pc", ifid_pc0, 32'd9);
    chk("redir_tgt_valid", {31'b0, valid0}, 32'd1);
    chk("redir_tgt_instr", ifid_instr0, 32'h1000_0009);

    redir0 = 1'b1; rpc0 = 32'd7;
    step();
    chk("pre_rst_addr", addr0, 32'd7);
    rst0 = 1'b1; stall0 = 1'b1; rpc0 = 32'd12;
    step();
    rst0 = 1'b0; stall0 = 1'b0; redir0 = 1'b0;
    chk("frst_addr", addr0, 32'd0);
    chk("frst_ifid_pc", ifid_pc0, 32'd0);
    chk("frst_ifid_instr", ifid_instr0, 32'd0);
    chk("frst_valid", {31'b0, valid0}, 32'd0);
    chk("frst_count", count0, 32'd0);
    step();
    step();
    chk("idle_addr", addr0, 32'd0);
    chk("idle_valid", {31'b0, valid0}, 32'd0);

    redir0 = 1'b1; rpc0 = 32'd5;
    step();
    redir0 = 1'b0;
    chk("idle_redir_addr", addr0, 32'd5);
    step();
    chk("idle_redir_stay", {31'b0, valid0}, 32'd0);
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk("restart_valid", {31'b0, valid0}, 32'd0);
    step();
    chk("restart_pc", ifid_pc0, 32'd5);
    chk("restart_valid2", {31'b0, valid0}, 32'd1);
    chk("restart_count", count0, 32'd1);

    // Wrap-around instance.
    chk("wrap_rst_addr", addr1, 32'hFFFF_FFFE);
    rst1 = 1'b0; start1 = 1'b1;
    step();
    start1 = 1'b0;
    step();
    chk("wrap_pc0", ifid_pc1, 32'hFFFF_FFFE);
    chk("wrap_valid0", {31'b0, valid1}, 32'd1);
    step();
    chk("wrap_pc1", ifid_pc1, 32'hFFFF_FFFF);
    chk("wrap_addr1", addr1, 32'd0);
    step();
    chk("wrap_pc2", ifid_pc1, 32'd0);
    chk("wrap_zero_instr", ifid_instr1, 32'd0);
    chk("wrap_zero_valid", {31'b0, valid1}, 32'd1);
    chk("wrap_no_halt", {31'b0, halted1}, 32'd0);
    step();
    chk("wrap_pc3", ifid_pc1, 32'd1);
    chk("wrap_instr3", ifid_instr1, 32'hB000_0001);
    chk("wrap_count", count1, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
